// File: rtl/audio_pkg.sv
`default_nettype none
// audio_pkg: shared waveform encodings, FSM states, constants and the quarter-wave sine ROM generator.
// Rev 1.0
package audio_pkg;

  localparam logic [1:0] WAVE_SQUARE = 2'd0;
  localparam logic [1:0] WAVE_SAW    = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;
  localparam logic [1:0] WAVE_SINE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    PUSH = 2'd2
  } state_t;

  localparam logic [11:0] SAMPLE_MID     = 12'h800;
  localparam int          SINE_LUT_DEPTH = 256;

  // pi in Q4.60 fixed point (hex expansion of pi, truncated)
  localparam logic [63:0] PI_Q60 = 64'h3243F6A8885A308D;

  // round(2047 * sin((idx + 0.5) * pi / 512)) via a fixed-point Taylor series,
  // evaluated only at elaboration time to fill the ROM.
  function automatic logic [10:0] sine_entry(input int idx);
    logic [127:0] x;
    logic [127:0] term;
    logic [127:0] sum;
    x    = (128'(2 * idx + 1) * 128'(PI_Q60)) >> 10;
    term = x;
    sum  = x;
    for (int n = 1; n <= 10; n++) begin
      term = (term * x) >> 60;
      term = (term * x) >> 60;
      term = term / 128'((2 * n) * (2 * n + 1));
      if (n % 2 == 1) sum = sum - term;
      else            sum = sum + term;
    end
    sum = (sum * 128'd2047 + (128'd1 << 59)) >> 60;
    return sum[10:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sine_lut.sv
`default_nettype none
// sine_lut: 256 x 11-bit quarter-wave sine magnitude ROM with registered output.
// Rev 1.0
module sine_lut
  import audio_pkg::*;
(
  input  logic        clk,
  input  logic [7:0]  addr,
  output logic [10:0] data
);

  logic [10:0] rom [SINE_LUT_DEPTH];

  for (genvar i = 0; i < SINE_LUT_DEPTH; i++) begin : g_rom
    localparam logic [10:0] ENTRY = sine_entry(i);
    assign rom[i] = ENTRY;
  end

  always_ff @(posedge clk) begin
    data <= rom[addr];
  end

endmodule
`default_nettype wire

// File: rtl/wave_gen.sv
`default_nettype none
// wave_gen: NCO audio source producing 12-bit offset-binary samples as single-cycle FIFO writes.
// Optional attenuation stage under WAVE_GEN_VOLUME_EN. Rev 1.0
module wave_gen
  import audio_pkg::*;
#(
  parameter int CPU_CLOCK_FREQ = 50_000_000,
  parameter int SAMPLE_RATE    = 48_000,
  parameter int PHASE_WIDTH    = 24,
  parameter int OUT_WIDTH      = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [PHASE_WIDTH-1:0] fcw,
  input  logic [1:0]             wave_sel,
  input  logic                   fifo_full,
`ifdef WAVE_GEN_VOLUME_EN
  input  logic [2:0]             volume,
`endif
  output logic [OUT_WIDTH-1:0]   wave,
  output logic                   wave_valid,
  output logic [15:0]            overrun_cnt
);

  localparam int SAMPLE_DIV = CPU_CLOCK_FREQ / SAMPLE_RATE;
  localparam int CNT_W      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  state_t                   state;
  state_t                   next_state;
  logic [CNT_W-1:0]         tick_cnt;
  logic                     tick;
  logic [PHASE_WIDTH-1:0]   phase;
  logic [PHASE_WIDTH-1:0]   shadow_fcw;
  logic [1:0]               shadow_sel;
  logic [7:0]               lut_addr;
  logic [10:0]              lut_data;
  logic [11:0]              shaped;
  logic [11:0]              sample;
  logic                     start;
  logic                     drop;
  logic                     calc_last;
  logic                     calc_done;

  assign tick = (tick_cnt == CNT_LAST);

  // Quadrant bit 0 mirrors the address so the quarter-wave table covers the full cycle.
  assign lut_addr = phase[PHASE_WIDTH-3 -: 8] ^ {8{phase[PHASE_WIDTH-2]}};

  sine_lut u_sine_lut (
    .clk  (clk),
    .addr (lut_addr),
    .data (lut_data)
  );

  always_comb begin
    shaped = SAMPLE_MID;
    case (shadow_sel)
      WAVE_SQUARE: shaped = phase[PHASE_WIDTH-1] ? 12'hFFF : 12'h000;
      WAVE_SAW:    shaped = phase[PHASE_WIDTH-1 -: 12];
      WAVE_TRI:    shaped = phase[PHASE_WIDTH-1] ? ~phase[PHASE_WIDTH-2 -: 12]
                                                 :  phase[PHASE_WIDTH-2 -: 12];
      WAVE_SINE:   shaped = phase[PHASE_WIDTH-1] ? (12'd2047 - {1'b0, lut_data})
                                                 : (12'd2048 + {1'b0, lut_data});
      default:     shaped = SAMPLE_MID;
    endcase
  end

`ifdef WAVE_GEN_VOLUME_EN
  logic [2:0]         shadow_vol;
  logic               calc_step;
  logic [11:0]        shaped_q;
  logic signed [12:0] centred;
  logic signed [12:0] scaled;

  assign calc_last = calc_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_vol <= 3'd0;
      calc_step  <= 1'b0;
      shaped_q   <= SAMPLE_MID;
    end else begin
      if (start) shadow_vol <= volume;
      calc_step <= (state == CALC) && !calc_step;
      if ((state == CALC) && !calc_step) shaped_q <= shaped;
    end
  end

  // Arithmetic shift about the midpoint keeps the attenuated sample centred on 0x800.
  always_comb begin
    centred = $signed({1'b0, shaped_q}) - 13'sd2048;
    scaled  = centred >>> shadow_vol;
    sample  = 12'(scaled + 13'sd2048);
  end
`else
  assign calc_last = 1'b1;
  assign sample    = shaped;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (tick && enable) next_state = CALC;
      CALC:    if (calc_last)      next_state = PUSH;
      PUSH:    if (!fifo_full)     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    wave_valid = (state == PUSH) && !fifo_full;
    start      = (state == IDLE) && tick && enable;
    drop       = (state != IDLE) && tick && enable;
    calc_done  = (state == CALC) && calc_last;
  end

  // A dropped tick still advances phase so pitch is preserved under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt    <= '0;
      phase       <= '0;
      shadow_fcw  <= '0;
      shadow_sel  <= WAVE_SQUARE;
      wave        <= SAMPLE_MID;
      overrun_cnt <= 16'd0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      phase    <= phase + (calc_done ? shadow_fcw : '0) + (drop ? shadow_fcw : '0);
      if (start) begin
        shadow_fcw <= fcw;
        shadow_sel <= wave_sel;
      end
      if (calc_done) wave <= sample;
      if (drop && (overrun_cnt != 16'hFFFF)) overrun_cnt <= overrun_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire
